// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the variable-latency data-memory responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous word RAM; a read during a write returns the old word.
module mem_responder_ram #(
  parameter int ADDR_BITS = 14
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          d,
  output logic [31:0]          q
);

  logic [31:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= d;
    q <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder for the CPU MEM stage: wait states, RAM access, done pulse.
//
// state  | meaning
// IDLE   | no request in flight, can accept
// WAIT   | counting down wait states, abortable by clear
// ACCESS | RAM driven with the latched request
// RESP   | done pulse, read data presented, can accept the next request
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS   = 14,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] data,
  input  logic        clear,
  output logic [31:0] q,
  output logic        done,
  output logic        err,
  output logic        busy
);

  localparam state_t FIRST_ST = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [ADDR_BITS-1:0]   addr_l;
  logic [31:0]            data_l;
  logic                   we_l;
  logic                   oor_l;
  logic [31:0]            q_hold;
  logic [31:0]            ram_q;
  logic                   accept_possible;
  logic                   accept;
  logic                   ram_we;
  logic                   resp_read;

  assign accept_possible = (state == ST_IDLE) | (state == ST_RESP);
  assign accept          = start & accept_possible & ~clear;
  assign busy            = (state == ST_WAIT) | (state == ST_ACCESS) | accept;
  // A synchronous reset landing on the ACCESS cycle must not let the write commit.
  assign ram_we          = (state == ST_ACCESS) & we_l & ~oor_l & ~reset;
  assign resp_read       = (state == ST_RESP) & ~we_l;

  // The RAM output register supplies read data during RESP; q_hold keeps it afterwards.
  assign q = resp_read ? (oor_l ? '0 : ram_q) : q_hold;

  mem_responder_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (addr_l),
    .d    (data_l),
    .q    (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      q_hold <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (resp_read) q_hold <= oor_l ? '0 : ram_q;
      if (accept) begin
        addr_l <= addr[ADDR_BITS-1:0];
        data_l <= data;
        we_l   <= we;
        oor_l  <= |addr[31:ADDR_BITS];
      end
      case (state)
        ST_IDLE, ST_RESP: begin
          state <= accept ? FIRST_ST : ST_IDLE;
          cnt   <= CNT_INIT;
        end
        ST_WAIT: begin
          if (clear)             state <= ST_IDLE;
          else if (cnt == '0)    state <= ST_ACCESS;
          else                   cnt   <= cnt - 1'b1;
        end
        ST_ACCESS: begin
          if (clear) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_RESP;
            done  <= 1'b1;
            err   <= oor_l;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: cycle vectors on a WAIT_CYCLES=2 instance, back-to-back run on a WAIT_CYCLES=0 instance.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, we_a, clr_a;
  logic [31:0] addr_a, data_a, q_a;
  logic        done_a, err_a, busy_a;

  logic        rst_b, start_b, we_b, clr_b;
  logic [31:0] addr_b, data_b, q_b;
  logic        done_b, err_b, busy_b;

  mem_responder #(.ADDR_BITS(14), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .addr(addr_a), .we(we_a),
    .data(data_a), .clear(clr_a), .q(q_a), .done(done_a), .err(err_a), .busy(busy_a)
  );

  mem_responder #(.ADDR_BITS(14), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .addr(addr_b), .we(we_b),
    .data(data_b), .clear(clr_b), .q(q_b), .done(done_b), .err(err_b), .busy(busy_b)
  );

  typedef struct {
    bit          rst, st, we, clr;
    logic [31:0] addr, data;
    bit          c, e_done, e_err, e_busy, cq;
    logic [31:0] e_q;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic v(input int rst, st, we, clr, input logic [31:0] addr, data,
                   input int c, ed, ee, eb, cq, input logic [31:0] eq);
    vec_t x;
    x.rst = (rst != 0); x.st = (st != 0); x.we = (we != 0); x.clr = (clr != 0);
    x.addr = addr; x.data = data;
    x.c = (c != 0); x.e_done = (ed != 0); x.e_err = (ee != 0); x.e_busy = (eb != 0);
    x.cq = (cq != 0); x.e_q = eq;
    vecs.push_back(x);
  endtask

  // Two WAIT cycles then ACCESS, no new inputs: busy high, no done.
  task automatic acc3();
    repeat (3) v(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got, want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b1; start_a = 1'b0; we_a = 1'b0; clr_a = 1'b0; addr_a = '0; data_a = '0;
    rst_b = 1'b1; start_b = 1'b0; we_b = 1'b0; clr_b = 1'b0; addr_b = '0; data_b = '0;

    // reset, seed 0x20, then reset held with a write request pending
    v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    v(0, 1, 1, 0, 'h20, 'h1234, 1, 0, 0, 1, 1, 0);
    acc3();
    v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    repeat (3) v(1, 1, 1, 0, 'h20, 'hBAD, 1, 0, 0, 1, 1, 0);
    v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    v(0, 1, 0, 0, 'h20, 0, 1, 0, 0, 1, 1, 0);
    acc3();
    // read 0x20 returns seed, back-to-back write 0x10
    v(0, 1, 1, 0, 'h10, 'hDEADBEEF, 1, 1, 0, 1, 1, 'h1234);
    acc3();
    v(0, 1, 0, 0, 'h10, 0, 1, 1, 0, 1, 1, 'h1234);
    acc3();
    v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 'hDEADBEEF);
    v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 'hDEADBEEF);
    // flush in WAIT
    v(0, 1, 1, 0, 7, 'h77, 1, 0, 0, 1, 1, 'hDEADBEEF);
    acc3();
    v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 'hDEADBEEF);
    v(0, 1, 1, 0, 7, 5, 1, 0, 0, 1, 0, 0);
    v(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    repeat (3) v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 'hDEADBEEF);
    v(0, 1, 0, 0, 7, 0, 1, 0, 0, 1, 0, 0);
    acc3();
    v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 'h77);
    // flush in ACCESS: write commits, no done
    v(0, 1, 1, 0, 7, 5, 1, 0, 0, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    v(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    repeat (3) v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 'h77);
    v(0, 1, 0, 0, 7, 0, 1, 0, 0, 1, 0, 0);
    acc3();
    // out of range: seed word 0, read and write 0x4000, word 0 intact
    v(0, 1, 1, 0, 0, 'hA5A5, 1, 1, 0, 1, 1, 5);
    acc3();
    v(0, 1, 0, 0, 'h4000, 0, 1, 1, 0, 1, 1, 5);
    acc3();
    v(0, 1, 1, 0, 'h4000, 'hFFFF, 1, 1, 1, 1, 1, 0);
    acc3();
    v(0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0);
    acc3();
    v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 'hA5A5);
    // reset during WAIT of a write to 7
    v(0, 1, 1, 0, 7, 'h999, 1, 0, 0, 1, 1, 'hA5A5);
    v(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 'hA5A5);
    repeat (4) v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    v(0, 1, 0, 0, 7, 0, 1, 0, 0, 1, 1, 0);
    acc3();
    v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 5);
    v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_a = vecs[i].rst; start_a = vecs[i].st; we_a = vecs[i].we; clr_a = vecs[i].clr;
      addr_a = vecs[i].addr; data_a = vecs[i].data;
      #2;
      if (vecs[i].c) begin
        chk("a_done", i, {31'b0, done_a}, {31'b0, vecs[i].e_done});
        chk("a_err",  i, {31'b0, err_a},  {31'b0, vecs[i].e_err});
        chk("a_busy", i, {31'b0, busy_a}, {31'b0, vecs[i].e_busy});
      end
      if (vecs[i].cq) chk("a_q", i, q_a, vecs[i].e_q);
    end

    // zero-wait instance: writes 1..3 then reads 1..3, each issued in the previous RESP
    @(negedge clk);
    rst_b = 1'b0; start_b = 1'b0;
    #2;
    chk("b_idle_busy", 0, {31'b0, busy_b}, 32'd0);
    chk("b_idle_q", 0, q_b, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start_b = 1'b1;
      we_b    = (i < 3);
      addr_b  = 32'(i % 3 + 1);
      data_b  = (i < 3) ? 32'h11 * 32'(i + 1) : 32'h0;
      #2;
      chk("b_start_busy", i, {31'b0, busy_b}, 32'd1);
      chk("b_start_done", i, {31'b0, done_b}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 3) chk("b_read_q", i, q_b, 32'h11 * 32'(i - 3));
      @(negedge clk);
      start_b = 1'b0;
      #2;
      chk("b_access_done", i, {31'b0, done_b}, 32'd0);
      chk("b_access_busy", i, {31'b0, busy_b}, 32'd1);
    end
    @(negedge clk);
    #2;
    chk("b_last_done", 0, {31'b0, done_b}, 32'd1);
    chk("b_last_q", 0, q_b, 32'h33);
    chk("b_last_err", 0, {31'b0, err_b}, 32'd0);
    @(negedge clk);
    #2;
    chk("b_after_done", 0, {31'b0, done_b}, 32'd0);
    chk("b_after_q", 0, q_b, 32'h33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Variable-latency memory responder serving the B32P CPU's data-memory port. It accepts one word request at a time from the MEM stage, inserts a configurable number of wait states, and then performs the read or write on an internal synchronous word RAM. It signals completion with a one-cycle `done` pulse, and holds `busy` high so the pipeline stall logic can freeze FE through MEM while an access is in flight. Requests cancelled by a pipeline flush (`clear`) are dropped without a response.

## Interface
- `ADDR_BITS`, default 14: RAM depth is 2^ADDR_BITS 32-bit words.
- `WAIT_CYCLES`, default 2: wait states inserted before the RAM access; legal range 0–15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request valid; sampled only when the block can accept a request.
- `addr`  in  32: word address.
- `we`  in  1: 1 = write, 0 = read.
- `data`  in  32: write data.
- `clear`  in  1: flush from the pipeline; aborts a request that has not yet reached ACCESS.
- `q`  out  32: read data; registered; holds its value until the next read completes.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: qualifies `done`; set when the address was out of range.
- `busy`  out  1: combinational stall request to the CPU.

## Operation
- Four-state FSM: IDLE, WAIT, ACCESS, RESP.
- **Accept.** A request is accepted when `start=1`, the state is IDLE or RESP, and `clear=0`.
  - `addr`, `we` and `data` are latched.
  - The range check is computed at accept: `oor = |addr[31:ADDR_BITS]`.
  - Next state is WAIT with `cnt = WAIT_CYCLES-1`, or ACCESS directly when `WAIT_CYCLES=0`.
- **WAIT.** Decrement `cnt`; go to ACCESS when `cnt=0`. If `clear=1`, go to IDLE: no write, no `done`.
- **ACCESS.**
  - Drive the RAM with the latched address.
  - RAM write enable = `we_l & ~oor_l`. The write commits at the end of this cycle even if `clear=1`.
  - Next state is RESP. If `clear=1`, `done` is suppressed (state goes to IDLE instead).
- **RESP.**
  - `done=1` and `err=oor_l`.
  - For a read: `q` = RAM output, or 0 if out of range.
  - For a write: `q` is unchanged.
  - Next state is ACCESS/WAIT if a new request is accepted this cycle, otherwise IDLE.
- `start` arriving in WAIT or ACCESS is ignored. The CPU is stalled in those states and must keep `start` asserted.
- Address bits above `ADDR_BITS-1` never alias: an out-of-range write is dropped and an out-of-range read returns 0, both with `err=1`.
- `busy = (state==WAIT) | (state==ACCESS) | (start & accept_possible & ~clear)`.
- `reset` takes priority over all other inputs:
  - FSM returns to IDLE; `q=0`, `done=0`, `err=0`, `cnt=0`.
  - Any in-flight request is dropped.
  - RAM contents are not cleared.

## Timing
- Reset values: `q=0`, `done=0`, `err=0`, `busy=0` (with `start=0`).
- Latency: `start` sampled at edge k gives `done` high during cycle k+WAIT_CYCLES+2.
  - `WAIT_CYCLES=0` gives 2-cycle latency.
  - `q` is valid in the same cycle as `done` and stays stable afterwards.
- `busy` is high from the start cycle through the ACCESS cycle and low in RESP. This lets the CPU advance in the RESP cycle and issue the next request back-to-back.
- Back-to-back throughput: one access every WAIT_CYCLES+2 cycles.
- `clear` is sampled each cycle:
  - In WAIT or on the start cycle: full abort.
  - In ACCESS: the write still commits, but there is no `done`.
  - In RESP: `done` is still emitted; the CPU discards it.
- Simultaneous `reset` and `start`: reset wins and the request is not accepted.

## Structure
- A shared package `mem_responder_pkg` holds:
  - the state encoding (IDLE=0, WAIT=1, ACCESS=2, RESP=3);
  - the `WAIT_CYCLES` counter width constant (4).
- One sub-module: `mem_responder_ram`, a single-port synchronous RAM.
  - Ports: `clk`, `we`, `addr[ADDR_BITS-1:0]`, `d`, `q`.
  - Read-during-write returns the old data.
  - No reset.
- The top level contains the FSM, wait counter, request latch, range check and output registers.

## Test plan
- **Reset.** Hold `reset` for 3 cycles with `start=1` → `q=0`, `done=0`, `busy=0` after release, and no RAM write occurs.
- **Write then read, `WAIT_CYCLES=2`.** Write `0xDEADBEEF` to address `0x10` at edge 0, then read `0x10` → write `done` in cycle 4; read `done` 4 cycles after its accept with `q=0xDEADBEEF`, `err=0`. Check that `busy` is high exactly on the start, WAIT and ACCESS cycles.
- **Back-to-back, `WAIT_CYCLES=0`.** Assert `start` in each RESP cycle to read addresses 1, 2, 3 (preloaded with 0x11, 0x22, 0x33) → `done` every 2 cycles with `q` = 0x11, 0x22, 0x33.
- **Flush.**
  - Write `0x5` to address 7, pulse `clear` during WAIT → no `done`; a later read of 7 returns the old value.
  - Repeat with `clear` during ACCESS → no `done`; a later read returns `0x5`.
- **Out of range, `ADDR_BITS=14`.** Read address `0x4000` → `done=1`, `err=1`, `q=0`. Write to `0x4000` → address `0x0000` is unchanged.
- **Reset mid-operation.** Assert `reset` during WAIT of a write → no `done`; the target address is unchanged; the next request completes normally.
